// File: rtl/mux_port_arbiter.sv
// rtl/mux_port_arbiter.sv - two-requester round-robin port arbiter with burst limit
// Drives the select of a 2:1 mux so producers A and B share one downstream write port.
module mux_port_arbiter #(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             ReqA,
  input  logic [WIDTH-1:0] DataA,
  input  logic             ReqB,
  input  logic [WIDTH-1:0] DataB,
  input  logic             OutReady,
  output logic             GrantA,
  output logic             GrantB,
  output logic             Sel,
  output logic             OutValid,
  output logic [WIDTH-1:0] OutData
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWN_A = 2'd1,
    S_OWN_B = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last_a;
  logic             r_sel;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_last_a_nxt;
  logic             w_sel_nxt;
  logic             w_beat;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_last_a <= 1'b0;
      r_sel    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_last_a <= w_last_a_nxt;
      r_sel    <= w_sel_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_last_a_nxt = r_last_a;
    case (r_state)
      S_IDLE: begin
        if (ReqA && ReqB)
          w_state_nxt = r_last_a ? S_OWN_B : S_OWN_A;
        else if (ReqA)
          w_state_nxt = S_OWN_A;
        else if (ReqB)
          w_state_nxt = S_OWN_B;
      end
      S_OWN_A: begin
        if (!ReqA)
          w_state_nxt = ReqB ? S_OWN_B : S_IDLE;
        else if (w_beat) begin
          if (r_cnt == LAST_BEAT) begin
            w_cnt_nxt = '0;
            if (ReqB) w_state_nxt = S_OWN_B;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      S_OWN_B: begin
        if (!ReqB)
          w_state_nxt = ReqA ? S_OWN_A : S_IDLE;
        else if (w_beat) begin
          if (r_cnt == LAST_BEAT) begin
            w_cnt_nxt = '0;
            if (ReqA) w_state_nxt = S_OWN_A;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Leaving an owner state (to the other side or to IDLE) records who was last served.
    if (w_state_nxt != r_state) begin
      w_cnt_nxt = '0;
      if (r_state == S_OWN_A)
        w_last_a_nxt = 1'b1;
      else if (r_state == S_OWN_B)
        w_last_a_nxt = 1'b0;
    end

    if (w_state_nxt == S_OWN_A)
      w_sel_nxt = 1'b1;
    else if (w_state_nxt == S_OWN_B)
      w_sel_nxt = 1'b0;
    else
      w_sel_nxt = r_sel;
  end

  always_comb begin
    GrantA   = (r_state == S_OWN_A);
    GrantB   = (r_state == S_OWN_B);
    Sel      = r_sel;
    OutValid = (GrantA && ReqA) || (GrantB && ReqB);
    w_beat   = OutValid && OutReady;
    OutData  = r_sel ? DataA : DataB;
  end

endmodule
